// File: rtl/montgomery_mult_radix.sv
// -----------------------------------------------------------------------------
// montgomery_mult_radix
//   Digit-serial Montgomery multiplier: y = a * b * R^-1 mod m, with
//   R = 2^(K*D) and D = ceil(m_size / K) clamped to 1 .. ceil(NBITS / K).
//   One K-bit digit of a is consumed per clock, followed by one clock of
//   final conditional subtraction. K = 1 gives the classic bit-serial form.
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   enable_p   : start pulse, only sampled while idle
//   a, b       : operands (a, b < m), latched on the accepting edge
//   m          : odd modulus, latched on the accepting edge
//   m_size     : bit length of m, sets the digit count D
//   m_inv      : -m^-1 mod 2^K
//   y          : result, held until the next completion
//   busy       : high from the accepting edge until the done edge
//   done_irq_p : one-cycle completion pulse
// -----------------------------------------------------------------------------
module montgomery_mult_radix #(
    parameter int NBITS = 2048,
    parameter int K     = 4,
    parameter int SW    = $clog2(NBITS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [SW-1:0]    m_size,
    input  logic [K-1:0]     m_inv,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p
);

    localparam int DMAX = (NBITS + K - 1) / K;
    localparam int CW   = $clog2(DMAX + 1);
    // Accumulator width: S < 2m always fits here without truncation.
    localparam int SWID = NBITS + K + 1;
    // One extra bit for T + q*m before the shift by K.
    localparam int TW   = SWID + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    // Number of K-bit digits covering m_size bits, clamped to the legal range.
    function automatic logic [CW-1:0] calc_digits(input logic [SW-1:0] sz);
        logic [SW:0]    sum_v;
        logic [SW:0]    quot_v;
        logic [CW-1:0]  d_v;
        sum_v  = {1'b0, sz} + (SW+1)'(K - 1);
        quot_v = sum_v / (SW+1)'(K);
        if (quot_v == '0) begin
            d_v = CW'(1);
        end else if (quot_v > (SW+1)'(DMAX)) begin
            d_v = CW'(DMAX);
        end else begin
            d_v = CW'(quot_v);
        end
        return d_v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [NBITS-1:0] a_q, a_d;     // shifted right by K per iteration
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] m_q, m_d;
    logic [NBITS-1:0] y_q, y_d;
    logic [K-1:0]     minv_q, minv_d;
    logic [CW-1:0]    dig_q, dig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SWID-1:0]  s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [K-1:0]     digit_s;
    logic [K-1:0]     q_s;
    logic [2*K-1:0]   qprod_s;
    logic [TW-1:0]    ab_s;
    logic [TW-1:0]    t_s;
    logic [TW-1:0]    qm_s;
    logic [TW-1:0]    u_s;
    logic [SWID-1:0]  s_next_s;
    logic             s_ge_m_s;
    logic [SWID-1:0]  s_sub_s;

    // One Montgomery digit step plus the final-subtract comparison.
    always_comb begin
        digit_s  = a_q[K-1:0];
        ab_s     = TW'(b_q) * TW'(digit_s);
        t_s      = TW'(s_q) + ab_s;
        // q makes the low K bits of T + q*m vanish so the shift is exact.
        qprod_s  = (2*K)'(t_s[K-1:0]) * (2*K)'(minv_q);
        q_s      = qprod_s[K-1:0];
        qm_s     = TW'(m_q) * TW'(q_s);
        u_s      = t_s + qm_s;
        s_next_s = SWID'(u_s >> K);
        s_ge_m_s = (s_q >= SWID'(m_q));
        s_sub_s  = s_q - SWID'(m_q);
    end

    // Sequencer: latch on start, iterate D digits, final subtract, pulse done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        y_d     = y_q;
        minv_d  = minv_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_p) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    minv_d  = m_inv;
                    dig_d   = calc_digits(m_size);
                    s_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                s_d   = s_next_s;
                a_d   = a_q >> K;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == (dig_q - CW'(1))) begin
                    state_d = ST_FINAL;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FINAL: begin
                y_d     = s_ge_m_s ? s_sub_s[NBITS-1:0] : s_q[NBITS-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            y_q     <= '0;
            minv_q  <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            y_q     <= y_d;
            minv_q  <= minv_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y          = y_q;
    assign busy       = busy_q;
    assign done_irq_p = done_q;

endmodule

// File: tb/tb_montgomery_mult_radix.sv
// -----------------------------------------------------------------------------
// Bench for montgomery_mult_radix: a bit-serial (K=1, 64-bit) instance and a
// full-size radix-16 (K=4, 2048-bit) instance. Stimulus pushes the expected
// result and timing into a per-instance queue; a monitor per instance pops
// and compares on every done pulse. The reference computes a*b mod m and
// then divides by 2 modulo m K*D times.
// -----------------------------------------------------------------------------
module tb_montgomery_mult_radix;

    localparam int N1  = 64;
    localparam int K1  = 1;
    localparam int SW1 = $clog2(N1) + 1;
    localparam int N4  = 2048;
    localparam int K4  = 4;
    localparam int SW4 = $clog2(N4) + 1;

    typedef struct {
        logic [2047:0] y;
        int            t;
        int            d;
        bit            chk_y;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           en1, en4;
    logic [N1-1:0]  a1, b1, m1, y1;
    logic [SW1-1:0] ms1;
    logic [K1-1:0]  mi1;
    logic           busy1, done1;
    logic [N4-1:0]  a4, b4, m4, y4;
    logic [SW4-1:0] ms4;
    logic [K4-1:0]  mi4;
    logic           busy4, done4;

    exp_t q1[$];
    exp_t q4[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    montgomery_mult_radix #(.NBITS(N1), .K(K1), .SW(SW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable_p(en1), .a(a1), .b(b1), .m(m1),
        .m_size(ms1), .m_inv(mi1), .y(y1), .busy(busy1), .done_irq_p(done1));

    montgomery_mult_radix #(.NBITS(N4), .K(K4), .SW(SW4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable_p(en4), .a(a4), .b(b4), .m(m4),
        .m_size(ms4), .m_inv(mi4), .y(y4), .busy(busy4), .done_irq_p(done4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2047:0] act, input logic [2047:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (low 128 bits)", name, act[127:0], req[127:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic int digits(input int msize, input int k, input int nbits);
        int d;
        int dmax;
        d    = (msize + k - 1) / k;
        dmax = (nbits + k - 1) / k;
        if (d < 1) d = 1;
        if (d > dmax) d = dmax;
        return d;
    endfunction

    // a*b*2^-nhalf mod m by repeated modular halving.
    function automatic logic [2047:0] mont_ref(input logic [2047:0] av, input logic [2047:0] bv,
                                               input logic [2047:0] mv, input int nhalf);
        logic [4095:0] x;
        logic [4095:0] mm;
        mm = {2048'b0, mv};
        x  = ({2048'b0, av} * {2048'b0, bv}) % mm;
        for (int i = 0; i < nhalf; i++) begin
            if (x[0]) x = (x + mm) >> 1;
            else      x = x >> 1;
        end
        return x[2047:0];
    endfunction

    // -m^-1 mod 16 by search.
    function automatic logic [3:0] minv16(input logic [2047:0] mv);
        logic [7:0] p;
        for (int j = 0; j < 16; j++) begin
            p = 8'(mv[3:0]) * 8'(j);
            if (p[3:0] == 4'hF) return 4'(j);
        end
        return 4'h0;
    endfunction

    // Caller is at a negedge; the following posedge samples the start.
    task automatic start1(input logic [2047:0] av, input logic [2047:0] bv,
                          input logic [2047:0] mv, input int ms, input bit cy);
        exp_t e;
        int   d;
        d   = digits(ms, K1, N1);
        a1  = av[N1-1:0];
        b1  = bv[N1-1:0];
        m1  = mv[N1-1:0];
        ms1 = SW1'(ms);
        mi1 = 1'b1;
        en1 = 1'b1;
        e.y     = cy ? mont_ref(av, bv, mv, K1 * d) : 2048'd0;
        e.t     = cyc + 1;
        e.d     = d;
        e.chk_y = cy;
        q1.push_back(e);
        @(negedge clk);
        en1 = 1'b0;
    endtask

    task automatic start4(input logic [2047:0] av, input logic [2047:0] bv,
                          input logic [2047:0] mv, input int ms, input logic [3:0] mi);
        exp_t e;
        int   d;
        d   = digits(ms, K4, N4);
        a4  = av;
        b4  = bv;
        m4  = mv;
        ms4 = SW4'(ms);
        mi4 = mi;
        en4 = 1'b1;
        e.y     = mont_ref(av, bv, mv, K4 * d);
        e.t     = cyc + 1;
        e.d     = d;
        e.chk_y = 1'b1;
        q4.push_back(e);
        @(negedge clk);
        en4 = 1'b0;
    endtask

    task automatic wait_q(input int which);
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (which == 1 && q1.size() == 0) break;
            if (which == 4 && q4.size() == 0) break;
        end
        if (i == 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_dut%0d: done never arrived within 1000 cycles", which);
            q1.delete();
            q4.delete();
        end
        @(negedge clk);
    endtask

    // Monitor for the K=1 instance.
    initial begin
        int   bcnt;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (busy1) bcnt++;
                if (done1) begin
                    if (q1.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut1_spurious_done: got done at cycle %0d required none", cyc);
                    end else begin
                        e = q1.pop_front();
                        if (e.chk_y) chk("dut1_y", 2048'(y1), e.y);
                        chk_int("dut1_latency", cyc - e.t, e.d + 1);
                        chk_int("dut1_busy_cycles", bcnt, e.d + 1);
                    end
                    bcnt = 0;
                end
            end
        end
    end

    // Monitor for the K=4 instance.
    initial begin
        int   bcnt;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (busy4) bcnt++;
                if (done4) begin
                    if (q4.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut4_spurious_done: got done at cycle %0d required none", cyc);
                    end else begin
                        e = q4.pop_front();
                        chk("dut4_y", y4, e.y);
                        chk_int("dut4_latency", cyc - e.t, e.d + 1);
                        chk_int("dut4_busy_cycles", bcnt, e.d + 1);
                    end
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2047:0] one;
        logic [2047:0] mask;
        logic [2047:0] mv, av, bv;
        int            bl, ms, i;

        one   = 2048'd1;
        rst_n = 1'b0;
        en1 = 1'b0; a1 = '0; b1 = '0; m1 = '0; ms1 = '0; mi1 = '0;
        en4 = 1'b0; a4 = '0; b4 = '0; m4 = '0; ms4 = '0; mi4 = '0;
        repeat (3) @(negedge clk);
        chk("reset_y1", 2048'(y1), 2048'd0);
        chk_int("reset_busy1", int'(busy1), 0);
        chk_int("reset_done1", int'(done1), 0);
        chk("reset_y4", y4, 2048'd0);
        chk_int("reset_busy4", int'(busy4), 0);
        chk_int("reset_done4", int'(done4), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // K=1 identity: b = 2^17 mod m.
        start1(2048'd5792, 2048'd58433, 2048'd72639, 17, 1'b1);
        wait_q(1);
        chk("k1_identity", 2048'(y1), 2048'd5792);

        // Small modulus: 16^-1 mod 13 = 9, then a = 0.
        start1(2048'd1, 2048'd1, 2048'd13, 4, 1'b1);
        wait_q(1);
        chk("k1_inv16_mod13", 2048'(y1), 2048'd9);
        start1(2048'd0, 2048'd1, 2048'd13, 4, 1'b1);
        wait_q(1);
        chk("k1_zero_operand", 2048'(y1), 2048'd0);

        // Even modulus: result unspecified, completion timing still checked.
        start1(2048'd5, 2048'd7, 2048'd72638, 17, 1'b0);
        wait_q(1);

        // K=4 identity: b = 2^20 mod m.
        start4(2048'd5792, 2048'd31630, 2048'd72639, 17, 4'd1);
        wait_q(4);
        chk("k4_identity", y4, 2048'd5792);

        // Latching, ignored restart at t+2, back-to-back start at t+7.
        start4(2048'd5792, 2048'd31630, 2048'd72639, 17, 4'd1);
        @(negedge clk);
        a4  = 2048'd1;
        en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        for (i = 0; i < 50; i++) begin
            if (done4) break;
            @(negedge clk);
        end
        if (i == 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL restart_wait_done: got no done within 50 cycles required one");
        end
        chk("latched_operand_y", y4, 2048'd5792);
        start4(2048'd1234, 2048'd31630, 2048'd72639, 17, 4'd1);
        chk_int("back_to_back_accepted", int'(busy4), 1);
        wait_q(4);
        chk("back_to_back_y", y4, 2048'd1234);

        // Mid-operation reset asserted before edge t+3.
        @(negedge clk);
        start4(2048'd5792, 2048'd31630, 2048'd72639, 17, 4'd1);
        @(negedge clk);
        rst_n = 1'b0;
        q4.delete();
        @(negedge clk);
        chk("midop_reset_y", y4, 2048'd0);
        chk_int("midop_reset_busy", int'(busy4), 0);
        chk_int("midop_reset_done", int'(done4), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        start4(2048'd4321, 2048'd31630, 2048'd72639, 17, 4'd1);
        wait_q(4);
        chk("after_reset_y", y4, 2048'd4321);

        // Full width: m = 2^2048-1, a = b = m-1, expected 1 at t+513.
        mv = '1;
        start4(mv - one, mv - one, mv, 2048, 4'd1);
        wait_q(4);
        chk("full_width_y", y4, 2048'd1);

        // Random operands on the K=1 instance.
        for (int n = 0; n < 8; n++) begin
            bl   = $urandom_range(2, N1);
            mask = (one << bl) - one;
            mv   = {1984'b0, $urandom, $urandom};
            mv   = (mv & mask) | (one << (bl - 1)) | one;
            av   = {1984'b0, $urandom, $urandom} % mv;
            bv   = {1984'b0, $urandom, $urandom} % mv;
            ms   = bl + $urandom_range(0, N1 - bl);
            start1(av, bv, mv, ms, 1'b1);
            wait_q(1);
        end

        // Random operands on the K=4 instance, up to 256-bit moduli.
        for (int n = 0; n < 5; n++) begin
            bl = $urandom_range(5, 256);
            mv = '0;
            av = '0;
            bv = '0;
            for (int w = 0; w < 8; w++) begin
                mv[w*32 +: 32] = $urandom;
                av[w*32 +: 32] = $urandom;
                bv[w*32 +: 32] = $urandom;
            end
            mask = (one << bl) - one;
            mv   = (mv & mask) | (one << (bl - 1)) | one;
            av   = av % mv;
            bv   = bv % mv;
            ms   = bl + $urandom_range(0, 8);
            start4(av, bv, mv, ms, minv16(mv));
            wait_q(4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/montgomery_mult_radix.md
Name: montgomery_mult_radix

Overview:
- Parametrised successor to the radix-2 Montgomery multiplier wrapper.
- Computes y = a·b·R⁻¹ mod m, with digit width (radix 2^K) selectable at elaboration and operand length selectable at run time.
- Operands are latched on a start pulse. The block iterates one K-bit digit of a per clock, then does a final conditional subtract, then pulses done.
- Sits under the crypto coprocessor's modular-exponentiation controller, which supplies pre-converted operands.

Parameters:
- NBITS, 2048, maximum modulus/operand width.
- K, 4, digit width in bits; radix = 2^K; 1 ≤ K ≤ 16; K=1 reproduces bit-serial behaviour.
- SW, $clog2(NBITS)+1, width of m_size.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_p  in  1  start pulse; sampled only in IDLE.
- a  in  NBITS  multiplicand; a < m required.
- b  in  NBITS  multiplier; b < m required.
- m  in  NBITS  modulus; must be odd.
- m_size  in  SW  bit length of m (m < 2^m_size).
- m_inv  in  K  −m⁻¹ mod 2^K; equals 1 when K=1.
- y  out  NBITS  result; held until the next completion.
- busy  out  1  high from the accepting edge until the done edge.
- done_irq_p  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; y=0, busy=0, done_irq_p=0; accumulator, digit counter and latched operands cleared. Reset mid-operation aborts immediately; no done pulse follows.
- Digit count: D = ceil(m_size/K), clamped to range 1..ceil(NBITS/K). R = 2^(K·D).
- States: IDLE → CALC → FINAL → IDLE.
- IDLE:
  - At an edge with enable_p=1 (edge t): latch a, b, m, m_inv and D; S←0; cnt←0; busy←1; go to CALC.
  - enable_p while not IDLE is ignored and not queued.
- CALC, edges t+1 … t+D: one iteration per edge, using the latched values.
  - a_i = digit cnt of a (bits K·cnt+K−1 .. K·cnt).
  - T = S + a_i·b.
  - q = (T[K−1:0]·m_inv) mod 2^K.
  - S ← (T + q·m) >> K.
  - cnt ← cnt+1; go to FINAL after the D-th iteration.
- Width rules: S is NBITS+K+1 bits wide with no truncation. The invariant S < 2m holds given a, b < m.
- FINAL, edge t+D+1:
  - y ← (S ≥ m) ? S−m : S, truncated to NBITS bits.
  - done_irq_p←1; busy←0; go to IDLE.
- done_irq_p returns to 0 at edge t+D+2.
- A new enable_p is accepted at edge t+D+2 at the earliest.
- Total latency: D+1 clocks from the sampling edge to the y/done update.
- Input changes on a, b, m, m_size and m_inv after edge t have no effect on the running operation.
- a=0 or b=0 gives y=0.
- Even m, or a/b ≥ m: result unspecified, but the FSM still completes in D+1 cycles (no hang).

Test Plan:
- Reset value and mid-op reset:
  - After reset, y=0, busy=0, done=0.
  - K=4: start, then assert rst_n=0 at edge t+3 → no done pulse, y=0; the next start completes normally.
- K=1 identity check (R = 2^17):
  - Inputs: m=72639, m_size=17, m_inv=1, a=5792, b=58433 (=2^17 mod m).
  - Required: done at t+18, y=5792, busy high for exactly 18 cycles.
- K=4 identity check (D=5, R=2^20):
  - Inputs: m=72639, m_size=17, m_inv=1, a=5792, b=31630 (=2^20 mod m).
  - Required: done at t+6, y=5792.
- Small-modulus inverse (K=1, R=16):
  - Inputs: m=13, m_size=4, m_inv=1, a=1, b=1.
  - Required: y=9 (16⁻¹ mod 13), done at t+5.
  - Repeat with a=0 → y=0.
- Operand latching and ignored restart:
  - Stimulus: start the K=4 identity-check case, then change a to 1 and pulse enable_p at t+2.
  - Required: exactly one done, y=5792.
  - A back-to-back start at t+7 (the t+D+2 edge) is accepted.
- Full-width boundary (NBITS=2048, K=4):
  - Inputs: m=2^2048−1, m_size=2048, m_inv=1, a=b=m−1.
  - Required: y=R⁻¹ mod m=1, done at t+513.
  - No overflow or X on y.
